// File: rtl/xswitch_egress_port.sv
// xswitch_egress_port: drains one switch port, filters by own address, buffers in a FIFO, counts rx/misroutes
module xswitch_egress_port #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      own_addr,
    input  logic                   port_en,
    input  logic                   data_rdy,
    input  logic [DATA_W-1:0]      data_out,
    input  logic [ADDR_W-1:0]      addr_out,
    output logic                   rd_en,
    output logic [DATA_W-1:0]      m_data,
    output logic [ADDR_W-1:0]      m_addr,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic [15:0]            rx_cnt,
    output logic [7:0]             misroute_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, RD, CAP} state_t;
    state_t state_q, state_d;
    logic rd_en_q, rd_en_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] rx_q, rx_d;
    logic [7:0] mis_q, mis_d;
    logic [DATA_W-1:0] dmem_q [DEPTH];
    logic [DATA_W-1:0] dmem_d [DEPTH];
    logic [ADDR_W-1:0] amem_q [DEPTH];
    logic [ADDR_W-1:0] amem_d [DEPTH];
    logic cap, match, push, pop, go;
    assign cap = state_q == CAP;
    assign match = addr_out == own_addr;
    assign push = cap && match;
    assign m_valid = cnt_q != '0;
    assign pop = m_valid && m_ready;
    // credit check counts the capture in progress but never a same-edge pop
    assign go = port_en && data_rdy && (cnt_q + CW'(push) < CW'(DEPTH));
    // while empty, point one slot behind the read pointer so the last popped word stays visible
    assign head = m_valid ? rd_ptr_q : rd_ptr_q - PW'(1);
    assign m_data = dmem_q[head];
    assign m_addr = amem_q[head];
    assign rd_en = rd_en_q;
    assign fifo_cnt = cnt_q;
    assign rx_cnt = rx_q;
    assign misroute_cnt = mis_q;
    // next-state: read sequencing, FIFO bookkeeping and counters
    always_comb begin
        state_d = state_q == RD ? CAP : go ? RD : IDLE;
        rd_en_d = state_d == RD;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        rx_d = push ? rx_q + 16'd1 : rx_q;
        mis_d = (cap && !match && mis_q != 8'hFF) ? mis_q + 8'd1 : mis_q;
        dmem_d = dmem_q;
        amem_d = amem_q;
        if (push) begin
            dmem_d[wr_ptr_q] = data_out;
            amem_d[wr_ptr_q] = addr_out;
        end
    end
    // state register; reset drops any word in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
            rx_q <= '0;
            mis_q <= '0;
            dmem_q <= '{default: '0};
            amem_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            rx_q <= rx_d;
            mis_q <= mis_d;
            dmem_q <= dmem_d;
            amem_q <= amem_d;
        end
    end
endmodule
